id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Parametrised decode-stage issue controller: the ID pipeline register (valid/payload, allowin handshake, flush)
//  plus operand bypass from NSTAGE downstream stages, load-use stall, and a single-outstanding long-latency
//  (div/mod) scoreboard. Sits between IF and EXE; the external combinational decoder reads ds_payload and
//  returns source/destination info in the same cycle.
// PARAMETERS
//  DATA_W     32  operand width
//  RADDR_W    5   register address width; address 0 is hardwired zero
//  PAYLOAD_W  64  IF->ID bus width ({inst,pc})
//  NSTAGE     3   forwarding sources; index 0 = youngest (EXE), NSTAGE-1 = oldest (WB)
//  CNT_W      32  stall performance counter width
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-high
//  in_valid      in   1                  IF has an instruction
//  in_allowin    out  1                  ID can accept this cycle
//  in_payload    in   PAYLOAD_W          IF->ID bus
//  flush         in   1                  branch/exception cancel of the held instruction
//  ds_payload    out  PAYLOAD_W          held payload, to decoder and EXE
//  rs1_addr/rs2_addr in RADDR_W          decoded source addresses
//  rs1_used/rs2_used in 1                source actually read by the instruction
//  dst_addr      in   RADDR_W            decoded destination
//  dst_we        in   1                  instruction writes dst_addr
//  is_long       in   1                  instruction is a long-latency op (div/mod)
//  rf_rdata1/2   in   DATA_W             regfile read data
//  fwd_valid/fwd_we/fwd_data_ok in NSTAGE per-stage valid, write-enable, result-available (0 = load in flight)
//  fwd_addr      in   NSTAGE*RADDR_W     per-stage destination, stage i at [i*RADDR_W +: RADDR_W]
//  fwd_data      in   NSTAGE*DATA_W      per-stage result
//  ll_done       in   1                  long-latency unit writes back this cycle
//  ll_done_addr  in   RADDR_W            its destination
//  rs1_value/rs2_value out DATA_W        bypassed operands
//  out_valid     out  1                  ID->EXE valid
//  out_ready     in   1                  EXE allowin
//  ll_busy       out  1                  long op outstanding
//  stall_cnt     out  CNT_W              cycles valid && !ready_go, saturating
// BEHAVIOUR
//  - Reset: ds_valid=0, ll_busy=0, pend_addr=0, stall_cnt=0; so out_valid=0, in_allowin=1. ds_payload not reset.
//  - in_allowin = !ds_valid || (ready_go && out_ready); out_valid = ds_valid && ready_go (combinational).
//  - Capture: in_valid && in_allowin -> ds_payload <= in_payload. ds_valid next: flush ? 0 : in_allowin ? in_valid : ds_valid.
//    Flush wins over simultaneous capture (incoming instruction dropped, payload may still load).
//  - Bypass per source s: if addr==0 -> rf_rdata (0). Else first matching i ascending with fwd_valid[i]&&fwd_we[i]&&
//    fwd_addr[i]==addr: fwd_data_ok[i] ? fwd_data[i] : stall (load-use). No match -> rf_rdata.
//  - hit_pend(a) = ll_busy && a!=0 && a==pend_addr.
//  - ready_go = !( (rs1_used&&load_use1) || (rs2_used&&load_use2) || (rs1_used&&hit_pend(rs1)) || (rs2_used&&hit_pend(rs2))
//    || (dst_we&&hit_pend(dst_addr)) [WAW] || (is_long&&ll_busy) ); ll_done in the same cycle clears hit_pend/busy terms
//    only when ll_done_addr==pend_addr (same-cycle release, value taken from fwd path).
//  - Scoreboard FSM IDLE/BUSY. issue_ll = out_valid && out_ready && is_long && dst_we && dst_addr!=0.
//    IDLE: issue_ll -> BUSY, pend_addr<=dst_addr. BUSY: ll_done && ll_done_addr==pend_addr -> IDLE;
//    simultaneous release and issue_ll -> stay BUSY with new pend_addr. ll_done to other address ignored.
//    is_long with dst 0 issues without entering BUSY. flush does not clear BUSY (op already in EXE).
//  - stall_cnt += 1 when ds_valid && !ready_go && !flush; holds at all-ones.
//  - Outputs hold while stalled; payload stable while ds_valid && !in_allowin.
// TESTING
//  1 reset; in_valid=1 payload 0x1C000000_00C00013 -> next cycle ds_valid=1, out_valid=1, in_allowin=out_ready.
//  2 rs1=5 used; fwd0 addr5 data 0xAA, fwd2 addr5 data 0xBB -> rs1_value=0xAA; rs1=0 with fwd addr0 -> 0.
//  3 fwd0 addr7 we, data_ok=0, rs2=7 used -> out_valid=0, stall_cnt+1/cycle; data_ok=1 next -> issue, rs2_value=fwd_data[0].
//  4 div dst 9 issues -> ll_busy=1; next insn reads r9 stalls until ll_done addr9, releases same cycle; second div stalls while busy.
//  5 flush with in_valid=1 held insn -> ds_valid=0 next cycle, ll_busy unchanged; reset while BUSY -> ll_busy=0.
//  6 stall_cnt preset to all-ones via long stall (CNT_W=4 build) -> stays 0xF.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: ID pipeline register, operand bypass with load-use
// detection, and a single-outstanding long-latency (div/mod) scoreboard.
module id_issue_ctrl #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int PAYLOAD_W = 64,
  parameter int NSTAGE    = 3,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allowin,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic                      flush,
  output logic [PAYLOAD_W-1:0]      ds_payload,
  input  logic [RADDR_W-1:0]        rs1_addr,
  input  logic [RADDR_W-1:0]        rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [RADDR_W-1:0]        dst_addr,
  input  logic                      dst_we,
  input  logic                      is_long,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NSTAGE-1:0]         fwd_valid,
  input  logic [NSTAGE-1:0]         fwd_we,
  input  logic [NSTAGE-1:0]         fwd_data_ok,
  input  logic [NSTAGE*RADDR_W-1:0] fwd_addr,
  input  logic [NSTAGE*DATA_W-1:0]  fwd_data,
  input  logic                      ll_done,
  input  logic [RADDR_W-1:0]        ll_done_addr,
  output logic [DATA_W-1:0]         rs1_value,
  output logic [DATA_W-1:0]         rs2_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ll_busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} ll_state_e;

  ll_state_e              ll_state_q;
  logic                   ds_valid_q, ds_valid_d;
  logic [PAYLOAD_W-1:0]   ds_payload_q;
  logic [RADDR_W-1:0]     pend_addr_q;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [NSTAGE-1:0] match1, match2;
  logic [DATA_W:0]   byp1, byp2;
  logic              load_use1, load_use2;
  logic              ll_release, pend_live, ready_go, issue_ll;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_match
      assign match1[gi] = fwd_valid[gi] && fwd_we[gi] &&
                          (fwd_addr[gi*RADDR_W +: RADDR_W] == rs1_addr);
      assign match2[gi] = fwd_valid[gi] && fwd_we[gi] &&
                          (fwd_addr[gi*RADDR_W +: RADDR_W] == rs2_addr);
    end
  endgenerate

  // Youngest matching stage wins; returns {load_use, value}.
  function automatic logic [DATA_W:0] bypass(input logic [RADDR_W-1:0] a,
                                             input logic [NSTAGE-1:0]  m,
                                             input logic [DATA_W-1:0]  rf);
    logic [DATA_W:0] r;
    logic            found;
    r     = {1'b0, rf};
    found = 1'b0;
    if (a != '0) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (!found && m[i]) begin
          found = 1'b1;
          if (fwd_data_ok[i]) r = {1'b0, fwd_data[i*DATA_W +: DATA_W]};
          else                r = {1'b1, rf};
        end
      end
    end
    return r;
  endfunction

  function automatic logic hit_pend(input logic [RADDR_W-1:0] a);
    return pend_live && (a != '0) && (a == pend_addr_q);
  endfunction

  always_comb begin
    byp1      = bypass(rs1_addr, match1, rf_rdata1);
    byp2      = bypass(rs2_addr, match2, rf_rdata2);
    load_use1 = byp1[DATA_W];
    load_use2 = byp2[DATA_W];
    rs1_value = byp1[DATA_W-1:0];
    rs2_value = byp2[DATA_W-1:0];
  end

  // A matching writeback releases the pending register in the same cycle.
  assign ll_busy    = (ll_state_q == S_BUSY);
  assign ll_release = ll_busy && ll_done && (ll_done_addr == pend_addr_q);
  assign pend_live  = ll_busy && !ll_release;

  assign ready_go = !((rs1_used && load_use1) || (rs2_used && load_use2) ||
                      (rs1_used && hit_pend(rs1_addr)) ||
                      (rs2_used && hit_pend(rs2_addr)) ||
                      (dst_we && hit_pend(dst_addr)) ||
                      (is_long && pend_live));

  assign out_valid  = ds_valid_q && ready_go;
  assign in_allowin = !ds_valid_q || (ready_go && out_ready);
  assign issue_ll   = out_valid && out_ready && is_long && dst_we && (dst_addr != '0);
  assign ds_payload = ds_payload_q;
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    ds_valid_d  = flush ? 1'b0 : (in_allowin ? in_valid : ds_valid_q);
    stall_cnt_d = stall_cnt_q;
    if (ds_valid_q && !ready_go && !flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_allowin) ds_payload_q <= in_payload;
    if (reset) begin
      ds_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      pend_addr_q <= '0;
      ll_state_q  <= S_IDLE;
    end else begin
      ds_valid_q  <= ds_valid_d;
      stall_cnt_q <= stall_cnt_d;
      case (ll_state_q)
        S_IDLE: begin
          if (issue_ll) begin
            ll_state_q  <= S_BUSY;
            pend_addr_q <= dst_addr;
          end
        end
        S_BUSY: begin
          if (issue_ll) pend_addr_q <= dst_addr;
          else if (ll_release) ll_state_q <= S_IDLE;
        end
        default: ll_state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Random-stimulus scoreboard bench for id_issue_ctrl with a small behavioural
// pipeline model; the bench also plays the role of the combinational decoder.
module tb_id_issue_ctrl;
  localparam int DW = 32, AW = 5, PW = 64, NS = 3, CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic              in_allowin, out_valid, ll_busy, ll_done = 1'b0;
  logic [PW-1:0]     in_payload = '0, ds_payload;
  logic [AW-1:0]     rs1_addr, rs2_addr, dst_addr, ll_done_addr = '0;
  logic              rs1_used, rs2_used, dst_we, is_long;
  logic [DW-1:0]     rf_rdata1 = '0, rf_rdata2 = '0, rs1_value, rs2_value;
  logic [NS-1:0]     fwd_valid = '0, fwd_we = '0, fwd_data_ok = '0;
  logic [NS*AW-1:0]  fwd_addr = '0;
  logic [NS*DW-1:0]  fwd_data = '0;
  logic [CW-1:0]     stall_cnt;

  // Bench decoder: fields are fixed bit slices of the held payload.
  assign rs1_addr = {2'b00, ds_payload[2:0]};
  assign rs2_addr = {2'b00, ds_payload[5:3]};
  assign dst_addr = {2'b00, ds_payload[8:6]};
  assign rs1_used = ds_payload[9];
  assign rs2_used = ds_payload[10];
  assign dst_we   = ds_payload[11];
  assign is_long  = (ds_payload[14:12] == 3'd0);

  id_issue_ctrl #(.DATA_W(DW), .RADDR_W(AW), .PAYLOAD_W(PW), .NSTAGE(NS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_payload(in_payload), .flush(flush), .ds_payload(ds_payload),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .dst_addr(dst_addr), .dst_we(dst_we), .is_long(is_long),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_data_ok(fwd_data_ok),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ll_done(ll_done), .ll_done_addr(ll_done_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .out_valid(out_valid), .out_ready(out_ready), .ll_busy(ll_busy), .stall_cnt(stall_cnt)
  );

  typedef struct { bit ov; bit allow; bit busy; int cnt; } st_t;
  typedef struct { logic [PW-1:0] pl; bit u1; logic [DW-1:0] v1; bit u2; logic [DW-1:0] v2; } iss_t;
  st_t  st_q[$];
  iss_t iss_q[$];

  int checks = 0, errors = 0;

  // Stimulus for forwarding stages, kept unpacked for the model.
  bit            fv[NS], fw[NS], fo[NS];
  logic [AW-1:0] fa[NS];
  logic [DW-1:0] fd[NS];

  // Model state: held instruction, pending long-op register (-1 = none), stall count.
  bit            m_valid;
  logic [PW-1:0] m_payload;
  int            m_pend;
  int            m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void operand(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                  output logic [DW-1:0] v, output bit stall);
    v = rf;
    stall = 1'b0;
    if (a != '0) begin
      for (int i = 0; i < NS; i++) begin
        if (fv[i] && fw[i] && fa[i] == a) begin
          if (fo[i]) v = fd[i];
          else stall = 1'b1;
          return;
        end
      end
    end
  endfunction

  task automatic randomize_inputs();
    reset      = 1'b0;
    in_valid   = ($urandom % 4) != 0;
    in_payload = {$urandom, $urandom};
    flush      = ($urandom % 16) == 0;
    out_ready  = ($urandom % 4) != 0;
    rf_rdata1  = $urandom;
    rf_rdata2  = $urandom;
    for (int i = 0; i < NS; i++) begin
      fv[i] = ($urandom % 2) != 0;
      fw[i] = ($urandom % 4) != 0;
      fo[i] = ($urandom % 4) != 0;
      fa[i] = AW'($urandom % 8);
      fd[i] = $urandom;
    end
    if (m_pend >= 0 && ($urandom % 4) == 0) begin
      ll_done      = 1'b1;
      ll_done_addr = (($urandom % 4) != 0) ? AW'(m_pend) : AW'($urandom % 8);
    end else begin
      ll_done      = ($urandom % 16) == 0;
      ll_done_addr = AW'($urandom % 8);
    end
  endtask

  task automatic pack_fwd();
    for (int i = 0; i < NS; i++) begin
      fwd_valid[i]   = fv[i];
      fwd_we[i]      = fw[i];
      fwd_data_ok[i] = fo[i];
      fwd_addr[i*AW +: AW] = fa[i];
      fwd_data[i*DW +: DW] = fd[i];
    end
  endtask

  // Predict this cycle's outputs, queue them, then advance the model across the edge.
  task automatic model_step();
    logic [AW-1:0] r1, r2, rd;
    bit u1, u2, we, lg, lu1, lu2, rel, live, blocked, go, ev, allow, fire;
    logic [DW-1:0] v1, v2;
    st_t  s;
    iss_t t;
    r1 = {2'b00, m_payload[2:0]};
    r2 = {2'b00, m_payload[5:3]};
    rd = {2'b00, m_payload[8:6]};
    u1 = m_payload[9];
    u2 = m_payload[10];
    we = m_payload[11];
    lg = (m_payload[14:12] == 3'd0);
    operand(r1, rf_rdata1, v1, lu1);
    operand(r2, rf_rdata2, v2, lu2);
    rel  = ll_done && m_pend >= 0 && int'(ll_done_addr) == m_pend;
    live = m_pend >= 0 && !rel;
    blocked = (u1 && lu1) || (u2 && lu2) ||
              (live && u1 && r1 != 0 && int'(r1) == m_pend) ||
              (live && u2 && r2 != 0 && int'(r2) == m_pend) ||
              (live && we && rd != 0 && int'(rd) == m_pend) ||
              (live && lg);
    go    = !blocked;
    ev    = m_valid && go;
    allow = !m_valid || (go && out_ready);
    fire  = ev && out_ready;
    s.ov = ev; s.allow = allow; s.busy = (m_pend >= 0); s.cnt = m_cnt;
    st_q.push_back(s);
    if (fire) begin
      t.pl = m_payload; t.u1 = u1; t.v1 = v1; t.u2 = u2; t.v2 = v2;
      iss_q.push_back(t);
    end
    if (in_valid && allow) m_payload = in_payload;
    if (reset) begin
      m_valid = 1'b0;
      m_pend  = -1;
      m_cnt   = 0;
    end else begin
      if (m_valid && !go && !flush && m_cnt < CNT_MAX) m_cnt++;
      m_valid = flush ? 1'b0 : (allow ? in_valid : m_valid);
      if (fire && lg && we && rd != 0) m_pend = int'(rd);
      else if (rel) m_pend = -1;
    end
  endtask

  always @(negedge clk) begin
    st_t  s;
    iss_t t;
    #2;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("out_valid", 64'(out_valid), 64'(s.ov));
      chk("in_allowin", 64'(in_allowin), 64'(s.allow));
      chk("ll_busy", 64'(ll_busy), 64'(s.busy));
      chk("stall_cnt", 64'(stall_cnt), 64'(s.cnt));
    end
    if (out_valid && out_ready) begin
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got payload %0h expected no issue", ds_payload);
      end else begin
        t = iss_q.pop_front();
        chk("issue_payload", ds_payload, t.pl);
        if (t.u1) chk("rs1_value", 64'(rs1_value), 64'(t.v1));
        if (t.u2) chk("rs2_value", 64'(rs2_value), 64'(t.v2));
      end
    end else if (iss_q.size() > 0) begin
      t = iss_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_issue: got no issue expected payload %0h", t.pl);
    end
  end

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    for (int i = 0; i < NS; i++) begin
      fv[i] = 0; fw[i] = 0; fo[i] = 0; fa[i] = '0; fd[i] = '0;
    end
    m_valid = 1'b0; m_payload = '0; m_pend = -1; m_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // First instruction after reset: known payload, EXE ready.
    randomize_inputs();
    in_valid = 1'b1; in_payload = 64'h1C000000_00C00013; flush = 1'b0;
    out_ready = 1'b1; ll_done = 1'b0;
    pack_fwd();
    #1 model_step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      randomize_inputs();
      if (cyc > 1500 && !did_rst && m_pend >= 0) begin
        reset = 1'b1;
        did_rst = 1'b1;
      end
      pack_fwd();
      #1 model_step();
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; ll_done = 1'b0;
    #3;
    checks++;
    if (!did_rst) begin
      errors++;
      $display("FAIL reset_while_busy: got not exercised expected exercised");
    end
    checks++;
    if (iss_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending issues expected 0", iss_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
